// File: rtl/counter_pkg.sv
// counter_pkg: shared mode encoding and default interval lengths for the
// programmable interval timer.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHORT = 2'd1,
    LONG  = 2'd2
  } cnt_mode_t;

  localparam int SHORT_CYCLES_DEF  = 16;
  localparam int LONG_CYCLES_DEF   = 64;
  localparam int ALMOST_CYCLES_DEF = 4;

endpackage : counter_pkg

// File: rtl/counter_if.sv
// counter_if: request/status bundle between the sequencing FSM (master)
// and the interval timer (slave).
interface counter_if;

  logic i_short_counter;  // level request for a short interval
  logic i_long_counter;   // level request for a long interval
  logic done_counter;     // terminal cycle of the active interval
  logic almost_done;      // cycles just before the terminal cycle
  logic done_FSM;         // registered one-cycle acknowledge

  modport master (
    output i_short_counter,
    output i_long_counter,
    input  done_counter,
    input  almost_done,
    input  done_FSM
  );

  modport slave (
    input  i_short_counter,
    input  i_long_counter,
    output done_counter,
    output almost_done,
    output done_FSM
  );

endinterface : counter_if

// File: rtl/counter_mode_fsm.sv
// counter_mode_fsm: picks the active interval mode from the two level
// requests (short wins over long) and flags every edge on which the mode
// changes so the count register can restart from zero.
module counter_mode_fsm
  import counter_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_short,
  input  logic      i_long,
  output cnt_mode_t o_mode,
  output logic      o_restart
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHORT = SHORT;
  localparam logic [1:0] ST_LONG  = LONG;

  logic [1:0] r_mode;
  logic [1:0] w_next_mode;

  // Next-mode selection with short-interval priority.
  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_next_mode = ST_IDLE;
    if (i_short)     w_next_mode = ST_SHORT;
    else if (i_long) w_next_mode = ST_LONG;
  end

  // Mode register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mode <= ST_IDLE;
    else        r_mode <= w_next_mode;
  end

  assign o_mode    = cnt_mode_t'(r_mode);
  assign o_restart = (w_next_mode != r_mode);

endmodule : counter_mode_fsm

// File: rtl/counter.sv
// counter: programmable interval timer. Counts clock cycles while a short
// or long request is held, auto-reloading at the end of each interval.
// done_counter marks the terminal cycle, done_FSM is its registered copy.
// Optional feature: define COUNTER_ALMOST_DONE_EN to generate almost_done;
// otherwise almost_done is tied low and its compare is not built.
module counter
  import counter_pkg::*;
#(
  parameter int SHORT_CYCLES  = SHORT_CYCLES_DEF,
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int ALMOST_CYCLES = ALMOST_CYCLES_DEF,
  parameter int CNT_W         = $clog2(LONG_CYCLES)
) (
  input  logic      clk,
  input  logic      rst_n,
  counter_if.slave  bus
);

  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_CYCLES - 1);

  cnt_mode_t        w_mode;
  logic             w_restart;
  logic [CNT_W-1:0] w_limit_m1;
  logic             w_active;
  logic             w_done;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done_fsm;

  counter_mode_fsm u_mode_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_short   (bus.i_short_counter),
    .i_long    (bus.i_long_counter),
    .o_mode    (w_mode),
    .o_restart (w_restart)
  );

  // Terminal count for the current mode; IDLE reuses the short value but
  // is masked by w_active everywhere it matters.
  always_comb begin
    w_limit_m1 = SHORT_LAST;
    case (w_mode)
      LONG:    w_limit_m1 = LONG_LAST;
      default: w_limit_m1 = SHORT_LAST;
    endcase
  end

  assign w_active = (w_mode != IDLE);
  assign w_done   = w_active && (r_cnt == w_limit_m1);

  // Count register: restart on mode change, hold at zero in IDLE, wrap
  // (auto-reload) after the terminal cycle, otherwise increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_restart || !w_active || (r_cnt == w_limit_m1))
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CNT_W'(1);
  end

  // Acknowledge flop: a pure one-cycle-delayed copy of done_counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done_fsm <= 1'b0;
    else        r_done_fsm <= w_done;
  end

  assign bus.done_counter = w_done;
  assign bus.done_FSM     = r_done_fsm;

`ifdef COUNTER_ALMOST_DONE_EN
  logic [CNT_W-1:0] w_almost_lo;

  // Lower edge of the almost window; ALMOST_CYCLES < SHORT_CYCLES-1 keeps
  // this from underflowing in either mode.
  assign w_almost_lo     = w_limit_m1 - CNT_W'(ALMOST_CYCLES);
  assign bus.almost_done = w_active && (r_cnt >= w_almost_lo) && (r_cnt < w_limit_m1);
`else
  assign bus.almost_done = 1'b0;
`endif

endmodule : counter

// File: tb/tb_counter.sv
// tb_counter: directed, table-driven bench for the interval timer at its
// default parameters (short 16, long 64, almost window 4).
module tb_counter;

  localparam int ALMOST = 4;

  typedef struct {
    logic req_s;
    logic req_l;
    int   n_cycles;
    int   limit;      // hand-picked expected interval length for the request
    logic prev_done;  // was the cycle before this segment a terminal cycle
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  counter_if bus ();

  counter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_done, input logic e_almost,
                           input logic e_fsm);
    check({tag, " done_counter"}, bus.done_counter, e_done);
    check({tag, " almost_done"},  bus.almost_done,  e_almost);
    check({tag, " done_FSM"},     bus.done_FSM,     e_fsm);
  endtask

  // Hold the given request for n cycles; cycle k is observed 1 time unit
  // after the k-th edge that samples the request.
  task automatic run_seg(input logic s, input logic l, input int n, input int limit,
                         input logic prev_done, input string name);
    logic e_done, e_alm, e_fsm;
    bus.i_short_counter = s;
    bus.i_long_counter  = l;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      e_done = ((k % limit) == 0);
`ifdef COUNTER_ALMOST_DONE_EN
      e_alm  = ((k % limit) >= (limit - ALMOST));
`else
      e_alm  = 1'b0;
`endif
      e_fsm  = (k == 1) ? prev_done : (((k - 1) % limit) == 0);
      check_all($sformatf("%s c%0d", name, k), e_done, e_alm, e_fsm);
    end
  endtask

  // Drop both requests and check the outputs settle; done_FSM may still
  // echo a terminal cycle that happened right before the release.
  task automatic idle_gap(input int n, input logic first_fsm, input string name);
    bus.i_short_counter = 1'b0;
    bus.i_long_counter  = 1'b0;
    for (int g = 1; g <= n; g++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("%s idle%0d", name, g), 1'b0, 1'b0, (g == 1) ? first_fsm : 1'b0);
    end
  endtask

  vec_t vecs[5];

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{req_s: 1'b1, req_l: 1'b0, n_cycles: 48,  limit: 16, prev_done: 1'b0};
    vecs[1] = '{req_s: 1'b0, req_l: 1'b1, n_cycles: 128, limit: 64, prev_done: 1'b0};
    vecs[2] = '{req_s: 1'b1, req_l: 1'b1, n_cycles: 20,  limit: 16, prev_done: 1'b0};
    vecs[3] = '{req_s: 1'b1, req_l: 1'b0, n_cycles: 16,  limit: 16, prev_done: 1'b0};
    vecs[4] = '{req_s: 1'b1, req_l: 1'b0, n_cycles: 10,  limit: 16, prev_done: 1'b0};

    // Reset held for three cycles with no requests.
    rst_n = 1'b0;
    bus.i_short_counter = 1'b0;
    bus.i_long_counter  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle_gap(2, 1'b0, "post_reset");

    // Short reload, long full, priority, drop on terminal, drop mid-interval.
    for (int i = 0; i < 5; i++) begin
      run_seg(vecs[i].req_s, vecs[i].req_l, vecs[i].n_cycles, vecs[i].limit,
              vecs[i].prev_done, $sformatf("vec%0d", i));
      idle_gap(3, ((vecs[i].n_cycles % vecs[i].limit) == 0), $sformatf("vec%0d", i));
    end

    // Long interrupted after 62 cycles, switched straight to short.
    run_seg(1'b0, 1'b1, 62, 64, 1'b0, "long_cut");
    run_seg(1'b1, 1'b0, 20, 16, 1'b0, "short_after_long");
    idle_gap(3, 1'b0, "switch");

    // Asynchronous reset in the terminal cycle of a short interval.
    run_seg(1'b1, 1'b0, 16, 16, 1'b0, "pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 1'b0, 1'b0);
    bus.i_short_counter = 1'b0;
    @(posedge clk);
    #1;
    check_all("async_reset_held", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle_gap(2, 1'b0, "post_async");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_counter

// File: doc/counter.md
# counter

Programmable interval timer used by the sequencing FSM to time its short and long phases. It counts clock cycles while a short- or long-interval request is held. It raises `almost_done` shortly before the interval expires and `done_counter` on the final cycle. `done_FSM` is a registered one-cycle acknowledge for the controlling FSM. The timer auto-reloads while the request stays asserted.

## Interface
- `SHORT_CYCLES`, default 16: length of a short interval in clock cycles; must be ≥ 2.
- `LONG_CYCLES`, default 64: length of a long interval; must be ≥ `SHORT_CYCLES`.
- `ALMOST_CYCLES`, default 4: number of cycles `almost_done` is high before the terminal cycle; must be < `SHORT_CYCLES` − 1.
- `CNT_W`, default `$clog2(LONG_CYCLES)`: count register width.

Ports:
- `clk`  input  1  single clock; all state on rising edge.
- `rst_n`  input  1  reset; one clock; reset is asynchronous and active-low.
- `i_short_counter`  input  1  request short interval (level).
- `i_long_counter`  input  1  request long interval (level).
- `done_counter`  output  1  high during the terminal cycle of the active interval.
- `almost_done`  output  1  high during the `ALMOST_CYCLES` cycles immediately preceding the terminal cycle.
- `done_FSM`  output  1  registered copy of `done_counter`, one cycle later, one-cycle pulse.

## Operation
- **Mode FSM states:** IDLE, SHORT, LONG.
- **Next mode:** SHORT if `i_short_counter`=1, else LONG if `i_long_counter`=1, else IDLE.
  - Short has priority when both requests are high.
- **Count register `cnt`:**
  - Loaded with 0 on any edge where the next mode differs from the current mode.
  - Also loaded with 0 in IDLE.
  - Otherwise increments by 1.
  - Wraps to 0 after `limit`−1, where `limit` = `SHORT_CYCLES` or `LONG_CYCLES` per mode. The wrap is an auto-reload while the request stays held.
- **`done_counter`:** `(mode != IDLE) && cnt == limit−1`, combinational from registers.
- **`almost_done`:** `(mode != IDLE) && limit−1−ALMOST_CYCLES <= cnt < limit−1`.
- **`done_FSM`:** a flop that samples `done_counter` every edge.
- **Arithmetic:** unsigned, `CNT_W` bits; the count never exceeds `limit`−1.
- **Mode switch mid-interval** (short↔long): restarts from 0 in the new mode. No done is produced for the abandoned interval.
- **Request dropped mid-interval:** go to IDLE, `cnt`=0, `done_counter`/`almost_done` low the next cycle.
- **Request dropped on the terminal cycle:** `done_FSM` still pulses, because it is a pure register of `done_counter`.
- **Reset mid-operation:** immediate return to reset values, regardless of clock.

## Timing
- **Reset values:** mode=IDLE, `cnt`=0; `done_counter`=0, `almost_done`=0, `done_FSM`=0.
- **Request to first count:** a request first sampled at edge E0 gives `cnt`=0 after E0 (cycle 1 of the interval).
- **`done_counter`:** high in cycle `limit`, i.e. after edge E0+`limit`−1, for exactly one cycle.
- **`almost_done`:** high in cycles `limit`−`ALMOST_CYCLES` through `limit`−1.
- **`done_FSM`:** high in the cycle after `done_counter` (after edge E0+`limit`). The next interval's cycle 1 coincides with it.
- **Period with the request held:** `done_counter` repeats every `limit` cycles.

## Configuration
- **`COUNTER_ALMOST_DONE_EN`**
  - Defined: `almost_done` is generated as above.
  - Undefined: `almost_done` is tied to 0 and its compare logic is omitted.
  - All other outputs are identical in both builds.

## Structure
- **`counter_pkg`:** `typedef enum logic [1:0] {IDLE, SHORT, LONG} cnt_mode_t`, plus default constants `SHORT_CYCLES_DEF`=16, `LONG_CYCLES_DEF`=64, `ALMOST_CYCLES_DEF`=4.
- **Sub-module `counter_mode_fsm`:** mode selection and priority, outputting the current mode and a `restart` strobe.
- **`counter`:** holds the count register, the terminal and almost compares, and the `done_FSM` flop.

## Test plan
Defaults are used throughout; cycle numbering starts at the first edge sampling the request.
- **Reset:** `rst_n`=0 for 3 cycles with both requests 0 → all outputs 0. Asserting `rst_n`=0 asynchronously mid-interval clears the outputs immediately.
- **Long interrupted:** long held 62 cycles then switched to short → no `done_counter`. `almost_done` is high in long cycles 60–62 (interval cut before cycle 63). Short restarts from 0.
- **Short auto-reload:** short held 48 cycles → `done_counter` in cycles 16, 32, 48; `almost_done` in cycles 12–15, 28–31, 44–47; `done_FSM` in cycles 17, 33, 49.
- **Long full:** long held 128 cycles → `done_counter` in cycles 64 and 128; `almost_done` in cycles 60–63 and 124–127.
- **Priority:** both requests high 20 cycles → short timing (`done_counter` in cycle 16).
- **Drop on terminal:** release the request in cycle 16 of short → `done_FSM` still pulses in cycle 17, then all outputs stay 0. With `COUNTER_ALMOST_DONE_EN` undefined, `almost_done` stays 0 throughout every scenario.
